reg_fifo: RTL and testbench
===========================

Name: reg_fifo

Overview:
- Small synchronous FIFO built from register storage; buffers 32-bit words ahead of the 32-bit pipeline register stage.
- Decouples a bursty producer from the register stage: the producer pushes with wr, and the consumer side pops with rd.
- Show-ahead (first-word-fall-through) read port: the head word is always visible on rdata while not empty.

Parameters:
- DATA_WIDTH, 32, width of each stored word.
- ADDR_WIDTH, 2, pointer width; depth = 2**ADDR_WIDTH (default 4 entries).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr  input  1  push request; wdata is written when accepted.
- wdata  input  DATA_WIDTH  data to push.
- rd  input  1  pop request; head entry is removed when accepted.
- rdata  output  DATA_WIDTH  head entry, combinational from storage[rptr].
- full  output  1  high when count == depth.
- empty  output  1  high when count == 0.
- count  output  ADDR_WIDTH+1  number of stored entries, 0..depth.

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high. No asynchronous paths.
- Reset: sampled on posedge clk while reset=1.
  - wptr=0, rptr=0, count=0, empty=1, full=0.
  - Storage contents are not cleared; rdata is don't-care while empty.
  - Reset wins over any simultaneous wr/rd. Mid-burst reset discards all contents in one cycle.
- Accept rules, evaluated each posedge:
  - push_ok = wr & (~full | rd).
  - pop_ok = rd & ~empty.
- Push: storage[wptr] <= wdata; wptr <= wptr+1.
- Pop: rptr <= rptr+1. The new head appears on rdata the next cycle.
- Pointers wrap modulo depth via natural ADDR_WIDTH overflow; no explicit compare.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or neither.
- full and empty are decoded from the registered count, never from pointer equality alone.
- Boundary conditions:
  - Full, wr only: write ignored; storage, wptr and count unchanged (overflow dropped silently).
  - Full, wr+rd: both accepted; count stays at depth. The new word lands in the slot just freed; wptr == rptr is legal.
  - Empty, rd only: ignored (underflow has no effect).
  - Empty, wr+rd: only the write is accepted; count becomes 1 and empty deasserts next cycle. The written word does not appear on rdata in the same cycle (no bypass).
  - Otherwise, wr+rd: both accepted, count unchanged.
- Latency:
  - Write to rdata-visible is 1 cycle when the FIFO was empty.
  - Flags update 1 cycle after the accepting edge.

Decomposition:
- No shared package is required; DATA_WIDTH and ADDR_WIDTH are module parameters only.
- One natural sub-module, fifo_ctrl: pointers, count, full/empty, and push_ok/pop_ok decode.
- Storage array stays in the top level: write-enabled register bank plus read mux on rptr.

Test Plan:
1. Reset then idle -> empty=1, full=0, count=0. Assert reset mid-stream with count=3 -> next cycle count=0, empty=1.
2. Push 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles -> full=1 and count=4 after the 4th edge. A 5th push of 0x55555555 is dropped, count stays 4.
3. From full, pop 4 times -> rdata sequence 0x11111111, 0x22222222, 0x33333333, 0x44444444, then empty=1. An extra rd leaves count=0 and rptr unchanged.
4. Wrap-around: 10 alternating push/pop pairs with data 0..9 -> each popped value equals the pushed value. Pointers wrap past 3 with no corruption.
5. Full, wr+rd same cycle with wdata=0xDEADBEEF -> count stays 4, the head advances, and 0xDEADBEEF is popped 4th.
6. Empty, wr+rd same cycle with wdata=0xCAFEF00D -> next cycle count=1, empty=0, rdata=0xCAFEF00D.

Source files
------------

// File: rtl/reg_fifo_pkg.sv
// Shared types for the register FIFO: the per-cycle operation code that
// drives the pointer and occupancy updates.
package reg_fifo_pkg;

   // One bit per accepted side: {push_ok, pop_ok}
   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_e;

   function automatic fifo_op_e op_decode(input logic push_ok, input logic pop_ok);
      return fifo_op_e'({push_ok, pop_ok});
   endfunction

endpackage

// File: rtl/reg_fifo_ctrl.sv
// Control path of the register FIFO: accept decode, read/write pointers,
// occupancy counter and the full/empty flags derived from it.
module reg_fifo_ctrl
   import reg_fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_wr,
   input  logic                  i_rd,
   output logic                  o_push_ok,
   output logic                  o_pop_ok,
   output logic [ADDR_WIDTH-1:0] o_wptr,
   output logic [ADDR_WIDTH-1:0] o_rptr,
   output logic [ADDR_WIDTH:0]   o_count,
   output logic                  o_full,
   output logic                  o_empty
);

   localparam int                DEPTH_I = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH = DEPTH_I[ADDR_WIDTH:0];

   logic [ADDR_WIDTH-1:0] r_wptr;
   logic [ADDR_WIDTH-1:0] r_rptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_push_ok;
   logic                  w_pop_ok;
   fifo_op_e              w_op;

   // Flags come from the registered count; pointers may be equal both when
   // empty and when full, so they cannot be used on their own.
   always_comb begin
      w_full    = (r_count == DEPTH);
      w_empty   = (r_count == '0);
      // A full FIFO still takes a write when the head leaves in the same cycle.
      w_push_ok = i_wr & (~w_full | i_rd);
      w_pop_ok  = i_rd & ~w_empty;
      w_op      = op_decode(w_push_ok, w_pop_ok);
   end

   // Pointer and occupancy update; pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push_ok) r_wptr <= r_wptr + ADDR_WIDTH'(1);
         if (w_pop_ok)  r_rptr <= r_rptr + ADDR_WIDTH'(1);
         case (w_op)
            OP_PUSH: r_count <= r_count + (ADDR_WIDTH+1)'(1);
            OP_POP:  r_count <= r_count - (ADDR_WIDTH+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_push_ok = w_push_ok;
   assign o_pop_ok  = w_pop_ok;
   assign o_wptr    = r_wptr;
   assign o_rptr    = r_rptr;
   assign o_count   = r_count;
   assign o_full    = w_full;
   assign o_empty   = w_empty;

endmodule

// File: rtl/reg_fifo.sv
// Register-based show-ahead FIFO in front of the pipeline register stage.
// Storage lives here; pointers and flags come from reg_fifo_ctrl.
module reg_fifo
   import reg_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  rd,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   count
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic                  w_push_ok;
   logic                  w_pop_ok;
   logic [ADDR_WIDTH-1:0] w_wptr;
   logic [ADDR_WIDTH-1:0] w_rptr;

   reg_fifo_ctrl #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ctrl (
      .clk       (clk),
      .reset     (reset),
      .i_wr      (wr),
      .i_rd      (rd),
      .o_push_ok (w_push_ok),
      .o_pop_ok  (w_pop_ok),
      .o_wptr    (w_wptr),
      .o_rptr    (w_rptr),
      .o_count   (count),
      .o_full    (full),
      .o_empty   (empty)
   );

   // Write-enabled register bank; contents survive reset, so a word read
   // while empty is stale and meaningless.
   always_ff @(posedge clk) begin
      if (!reset && w_push_ok) r_mem[w_wptr] <= wdata;
   end

   // Show-ahead read: head word straight from storage, no write bypass.
   always_comb begin
      rdata = r_mem[w_rptr];
   end

endmodule

// File: tb/tb_reg_fifo.sv
// Directed bench for reg_fifo: reset, fill/overflow, drain/underflow,
// wrap-around, and the simultaneous push/pop corner cases.
module tb_reg_fifo;

   logic        clk;
   logic        reset;
   logic        wr;
   logic [31:0] wdata;
   logic        rd;
   logic [31:0] rdata;
   logic        full;
   logic        empty;
   logic [2:0]  count;

   int total = 0;
   int bad   = 0;

   reg_fifo #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .wr    (wr),
      .wdata (wdata),
      .rd    (rd),
      .rdata (rdata),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Apply inputs, take one rising edge, settle 1 time unit past it.
   task automatic cyc(input logic w, input logic r, input logic [31:0] d);
      wr    = w;
      rd    = r;
      wdata = d;
      @(posedge clk);
      #1;
      wr    = 1'b0;
      rd    = 1'b0;
      wdata = '0;
   endtask

   task automatic chk_state(input string tag, input logic [2:0] c,
                            input logic f, input logic e);
      chk({tag, "_count"}, 32'(count), 32'(c));
      chk({tag, "_full"},  32'(full),  32'(f));
      chk({tag, "_empty"}, 32'(empty), 32'(e));
   endtask

   initial begin
      logic [31:0] words [4];
      words[0] = 32'h1111_1111;
      words[1] = 32'h2222_2222;
      words[2] = 32'h3333_3333;
      words[3] = 32'h4444_4444;

      reset = 1'b1; wr = 1'b0; rd = 1'b0; wdata = '0;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      cyc(1'b0, 1'b0, '0);
      chk_state("reset_idle", 3'd0, 1'b0, 1'b1);

      // Mid-stream reset with three entries held, push asserted alongside.
      cyc(1'b1, 1'b0, 32'hA0A0_A0A0);
      cyc(1'b1, 1'b0, 32'hA1A1_A1A1);
      cyc(1'b1, 1'b0, 32'hA2A2_A2A2);
      chk_state("pre_reset", 3'd3, 1'b0, 1'b0);
      reset = 1'b1;
      cyc(1'b1, 1'b1, 32'hA3A3_A3A3);
      reset = 1'b0;
      chk_state("mid_reset", 3'd0, 1'b0, 1'b1);

      // Fill to depth, then an overflow push that must be dropped.
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b0, words[i]);
         chk("fill_count", 32'(count), 32'(i + 1));
      end
      chk_state("filled", 3'd4, 1'b1, 1'b0);
      chk("filled_head", rdata, 32'h1111_1111);
      cyc(1'b1, 1'b0, 32'h5555_5555);
      chk_state("overflow", 3'd4, 1'b1, 1'b0);
      chk("overflow_head", rdata, 32'h1111_1111);

      // Drain in order; the dropped word must not surface.
      for (int i = 0; i < 4; i++) begin
         chk("drain_data", rdata, words[i]);
         cyc(1'b0, 1'b1, '0);
      end
      chk_state("drained", 3'd0, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, '0);
      chk_state("underflow", 3'd0, 1'b0, 1'b1);
      // rptr must still equal wptr: a fresh push becomes the head.
      cyc(1'b1, 1'b0, 32'h7777_7777);
      chk("after_underflow_head", rdata, 32'h7777_7777);
      chk_state("after_underflow", 3'd1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, '0);
      chk_state("after_underflow_pop", 3'd0, 1'b0, 1'b1);

      // Wrap-around: pointers pass the top several times.
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 1'b0, 32'(i));
         chk("wrap_data", rdata, 32'(i));
         chk("wrap_count1", 32'(count), 32'd1);
         cyc(1'b0, 1'b1, '0);
         chk("wrap_empty", 32'(empty), 32'd1);
      end

      // Full with push and pop together: occupancy holds, head advances.
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, words[i]);
      chk_state("full2", 3'd4, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 32'hDEAD_BEEF);
      chk_state("full_both", 3'd4, 1'b1, 1'b0);
      chk("full_both_head", rdata, 32'h2222_2222);
      for (int i = 1; i < 4; i++) begin
         chk("full_both_drain", rdata, words[i]);
         cyc(1'b0, 1'b1, '0);
      end
      chk("full_both_last", rdata, 32'hDEAD_BEEF);
      cyc(1'b0, 1'b1, '0);
      chk_state("full_both_end", 3'd0, 1'b0, 1'b1);

      // Empty with push and pop together: only the write lands, no bypass.
      wr = 1'b1; rd = 1'b1; wdata = 32'hCAFE_F00D;
      #1;
      chk("empty_both_nobypass", 32'(empty), 32'd1);
      @(posedge clk); #1;
      wr = 1'b0; rd = 1'b0; wdata = '0;
      chk_state("empty_both", 3'd1, 1'b0, 1'b0);
      chk("empty_both_data", rdata, 32'hCAFE_F00D);

      // Ordinary push+pop at partial occupancy keeps count.
      cyc(1'b1, 1'b0, 32'hBEEF_0001);
      cyc(1'b1, 1'b1, 32'hBEEF_0002);
      chk_state("mid_both", 3'd2, 1'b0, 1'b0);
      chk("mid_both_head", rdata, 32'hBEEF_0001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
